// File: rtl/ex_fw_ctrl.sv
// EX-stage forwarding / hazard controller.
// Shadows the rd tags of the instructions in EX and MEM and decides, for the
// instruction sitting in ID, which bypass stage feeds the single EX bypass bus
// and which operands take it. Raises stall_o on load-use hazards, on rs1/rs2
// stage conflicts and while a multi-cycle op occupies EX.
// Producers already in WB while the consumer is in ID are not tracked: they
// have left the pipeline before the consumer reaches EX, so the register file
// (which writes before it reads) supplies the value.
module ex_fw_ctrl #(
    parameter int unsigned RA_W       = 5,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [RA_W-1:0]  id_rs1_i,
    input  logic [RA_W-1:0]  id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [RA_W-1:0]  id_rd_i,
    input  logic             id_we_i,
    input  logic             id_load_i,
    input  logic             id_mc_i,
    input  logic             mc_done_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [1:0]       fw_stage_o,
    output logic [1:0]       fw_regs_o,
    output logic             mc_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);

    // Bypass stage encodings (as seen by the instruction once it is in EX).
    localparam logic [1:0] FwNone = 2'b00;
    localparam logic [1:0] FwMem  = 2'b01;
    localparam logic [1:0] FwWb   = 2'b10;

    // Timeout counter only needs to reach MC_TIMEOUT-1.
    localparam int unsigned TO_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = (MC_TIMEOUT == 0) ? '0 : TO_W'(MC_TIMEOUT - 1);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            load;
    } tag_t;

    typedef enum logic [0:0] {
        StIdle,
        StMcBusy
    } state_e;

    state_e           state_q, state_d;
    tag_t             ex_q, ex_d;
    tag_t             mem_q, mem_d;
    logic [1:0]       fw_stage_q, fw_stage_d;
    logic [1:0]       fw_regs_q, fw_regs_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             err_q, err_d;

    logic [2:0] sel_rs1, sel_rs2;
    logic       lu_rs1, lu_rs2;
    logic [1:0] stg_rs1, stg_rs2;
    logic       hz_lu, hz_cf;
    logic [1:0] dec_stage, dec_regs;
    logic       id_go;
    logic       hold;

    // Producer tag hit: writes a nonzero register equal to r.
    function automatic logic tag_match(input tag_t t, input logic [RA_W-1:0] r);
        return t.valid & t.we & (t.rd == r) & (r != '0);
    endfunction

    // Per-source decision, returned as {load_use, stage}. Youngest producer wins.
    function automatic logic [2:0] src_sel(input logic            used,
                                           input logic [RA_W-1:0] r,
                                           input tag_t            ex_t,
                                           input tag_t            mem_t);
        logic [2:0] res;
        res = {1'b0, FwNone};
        if (used) begin
            if (tag_match(ex_t, r)) begin
                res = ex_t.load ? {1'b1, FwNone} : {1'b0, FwMem};
            end else if (tag_match(mem_t, r)) begin
                res = {1'b0, FwWb};
            end
        end
        return res;
    endfunction

    assign sel_rs1 = src_sel(id_use_rs1_i, id_rs1_i, ex_q, mem_q);
    assign sel_rs2 = src_sel(id_use_rs2_i, id_rs2_i, ex_q, mem_q);
    assign lu_rs1  = sel_rs1[2];
    assign lu_rs2  = sel_rs2[2];
    assign stg_rs1 = sel_rs1[1:0];
    assign stg_rs2 = sel_rs2[1:0];

    // Hazard classification and the bypass decision for the ID instruction.
    always_comb begin
        hz_lu     = lu_rs1 | lu_rs2;
        // One bypass bus: two forwarded sources must come from the same stage.
        hz_cf     = (stg_rs1 != FwNone) & (stg_rs2 != FwNone) & (stg_rs1 != stg_rs2);
        dec_stage = (stg_rs1 != FwNone) ? stg_rs1 : stg_rs2;
        dec_regs  = {stg_rs2 != FwNone, stg_rs1 != FwNone};
    end

    assign id_go = id_valid_i & ~flush_i;
    // EX is frozen while the multi-cycle unit works; the done cycle advances normally.
    assign hold  = (state_q == StMcBusy) & ~mc_done_i;

    // FSM next state and the combinational stall.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall_o = id_go & (hz_lu | hz_cf);
                if (id_go & ~(hz_lu | hz_cf) & id_mc_i) begin
                    state_d = StMcBusy;
                end
            end
            StMcBusy: begin
                // flush_i only kills ID here; EX is still occupied.
                stall_o = 1'b1;
                if (mc_done_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Tag pipeline and registered bypass selects.
    always_comb begin
        ex_d       = ex_q;
        mem_d      = mem_q;
        fw_stage_d = fw_stage_q;
        fw_regs_d  = fw_regs_q;
        if (hold) begin
            mem_d = '0;
        end else begin
            mem_d = ex_q;
            if (id_go & ~stall_o) begin
                ex_d       = '{valid: 1'b1, rd: id_rd_i, we: id_we_i, load: id_load_i};
                fw_stage_d = dec_stage;
                fw_regs_d  = dec_regs;
            end else begin
                ex_d       = '0;
                fw_stage_d = FwNone;
                fw_regs_d  = 2'b00;
            end
        end
    end

    // Saturating stall counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Multi-cycle timeout watchdog; the error is sticky, the FSM keeps waiting.
    always_comb begin
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (state_q != StMcBusy) begin
            to_cnt_d = '0;
        end else if (!mc_done_i && (MC_TIMEOUT != 0)) begin
            if (to_cnt_q == TO_MAX) begin
                err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ex_q        <= '0;
            mem_q       <= '0;
            fw_stage_q  <= FwNone;
            fw_regs_q   <= 2'b00;
            stall_cnt_q <= '0;
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            fw_stage_q  <= fw_stage_d;
            fw_regs_q   <= fw_regs_d;
            stall_cnt_q <= stall_cnt_d;
            to_cnt_q    <= to_cnt_d;
            err_q       <= err_d;
        end
    end

    assign fw_stage_o  = fw_stage_q;
    assign fw_regs_o   = fw_regs_q;
    assign mc_busy_o   = (state_q == StMcBusy);
    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ex_fw_ctrl.sv
// Directed bench for ex_fw_ctrl. Inputs change on the falling edge; the
// combinational stall is sampled 1ns later, registered outputs 1ns after the
// rising edge.
module tb_ex_fw_ctrl;

    localparam int unsigned RA_W       = 5;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MC_TIMEOUT = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             id_valid_i = 1'b0;
    logic [RA_W-1:0]  id_rs1_i = '0;
    logic [RA_W-1:0]  id_rs2_i = '0;
    logic             id_use_rs1_i = 1'b0;
    logic             id_use_rs2_i = 1'b0;
    logic [RA_W-1:0]  id_rd_i = '0;
    logic             id_we_i = 1'b0;
    logic             id_load_i = 1'b0;
    logic             id_mc_i = 1'b0;
    logic             mc_done_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             stall_o;
    logic [1:0]       fw_stage_o;
    logic [1:0]       fw_regs_o;
    logic             mc_busy_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             err_o;

    int errors = 0;
    int checks = 0;

    ex_fw_ctrl #(
        .RA_W       (RA_W),
        .CNT_W      (CNT_W),
        .MC_TIMEOUT (MC_TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .id_valid_i   (id_valid_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .id_rd_i      (id_rd_i),
        .id_we_i      (id_we_i),
        .id_load_i    (id_load_i),
        .id_mc_i      (id_mc_i),
        .mc_done_i    (mc_done_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .fw_stage_o   (fw_stage_o),
        .fw_regs_o    (fw_regs_o),
        .mc_busy_o    (mc_busy_o),
        .stall_cnt_o  (stall_cnt_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Present one instruction in ID.
    task automatic id_set(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic ld, input logic mc);
        id_valid_i   = 1'b1;
        id_rs1_i     = rs1;
        id_rs2_i     = rs2;
        id_use_rs1_i = u1;
        id_use_rs2_i = u2;
        id_rd_i      = rd;
        id_we_i      = 1'b1;
        id_load_i    = ld;
        id_mc_i      = mc;
    endtask

    task automatic id_none();
        id_valid_i   = 1'b0;
        id_use_rs1_i = 1'b0;
        id_use_rs2_i = 1'b0;
        id_we_i      = 1'b0;
        id_load_i    = 1'b0;
        id_mc_i      = 1'b0;
    endtask

    // Empty EX and MEM with bubbles.
    task automatic drain();
        @(negedge clk_i);
        id_none();
        repeat (3) @(posedge clk_i);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
        checks++; if (fw_stage_o !== 2'b00) begin errors++; $display("FAIL reset_stage: got %b want 00", fw_stage_o); end
        checks++; if (fw_regs_o !== 2'b00) begin errors++; $display("FAIL reset_regs: got %b want 00", fw_regs_o); end
        checks++; if (mc_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", mc_busy_o); end
        checks++; if (stall_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err_o); end
        #10 rst_ni = 1'b1;
    endtask

    // ADD x5 in EX, consumer rs1=x5 rs2=x6 -> MEM bypass on rs1.
    task automatic test_fwd_mem();
        @(negedge clk_i); id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
        @(negedge clk_i); id_set(5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mem_stall: got %0b want 0", stall_o); end
        @(posedge clk_i); #1;
        checks++; if (fw_stage_o !== 2'b01) begin errors++; $display("FAIL mem_stage: got %b want 01", fw_stage_o); end
        checks++; if (fw_regs_o !== 2'b01) begin errors++; $display("FAIL mem_regs: got %b want 01", fw_regs_o); end
    endtask

    // LW x7 in EX, consumer reads x7 on rs2: one stall, then WB bypass.
    task automatic test_load_use();
        drain();
        @(negedge clk_i); id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        @(negedge clk_i); id_set(5'd0, 5'd7, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", stall_o); end
        @(posedge clk_i); #1;
        checks++; if ({fw_stage_o, fw_regs_o} !== 4'b0000) begin errors++; $display("FAIL lu_bubble: got %b want 0000", {fw_stage_o, fw_regs_o}); end
        checks++; if (stall_cnt_o !== 4'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt_o); end
        @(negedge clk_i); #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_release: got %0b want 0", stall_o); end
        @(posedge clk_i); #1;
        checks++; if (fw_stage_o !== 2'b10) begin errors++; $display("FAIL lu_stage: got %b want 10", fw_stage_o); end
        checks++; if (fw_regs_o !== 2'b10) begin errors++; $display("FAIL lu_regs: got %b want 10", fw_regs_o); end
    endtask

    // Flush during a load-use stall drops the stall and inserts a bubble.
    task automatic test_flush();
        drain();
        @(negedge clk_i); id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        @(negedge clk_i); id_set(5'd7, 5'd0, 1'b1, 1'b0, 5'd21, 1'b0, 1'b0);
        #1; flush_i = 1'b1; #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0b want 0", stall_o); end
        @(posedge clk_i); #1;
        checks++; if (stall_cnt_o !== 4'd1) begin errors++; $display("FAIL flush_cnt: got %0d want 1", stall_cnt_o); end
        // The killed x21 writer must not be in EX now.
        @(negedge clk_i); flush_i = 1'b0; id_set(5'd21, 5'd0, 1'b1, 1'b0, 5'd22, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        checks++; if ({fw_stage_o, fw_regs_o} !== 4'b0000) begin errors++; $display("FAIL flush_killed: got %b want 0000", {fw_stage_o, fw_regs_o}); end
    endtask

    // rs1 producer in EX, rs2 producer in MEM: conflict stall, then the
    // rs1 producer has moved to MEM (WB bypass) and rs2 comes from the RF.
    task automatic test_conflict();
        drain();
        @(negedge clk_i); id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0);
        @(negedge clk_i); id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
        @(negedge clk_i); id_set(5'd3, 5'd4, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL cf_stall: got %0b want 1", stall_o); end
        @(posedge clk_i); #1;
        checks++; if ({fw_stage_o, fw_regs_o} !== 4'b0000) begin errors++; $display("FAIL cf_bubble: got %b want 0000", {fw_stage_o, fw_regs_o}); end
        checks++; if (stall_cnt_o !== 4'd2) begin errors++; $display("FAIL cf_cnt: got %0d want 2", stall_cnt_o); end
        @(negedge clk_i); #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL cf_release: got %0b want 0", stall_o); end
        @(posedge clk_i); #1;
        checks++; if (fw_stage_o !== 2'b10) begin errors++; $display("FAIL cf_stage: got %b want 10", fw_stage_o); end
        checks++; if (fw_regs_o !== 2'b01) begin errors++; $display("FAIL cf_regs: got %b want 01", fw_regs_o); end
    endtask

    // Same source twice, x0 producer, and unused sources.
    task automatic test_both_x0();
        drain();
        @(negedge clk_i); id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
        @(negedge clk_i); id_set(5'd9, 5'd9, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL both_stall: got %0b want 0", stall_o); end
        @(posedge clk_i); #1;
        checks++; if ({fw_stage_o, fw_regs_o} !== 4'b0111) begin errors++; $display("FAIL both_sel: got %b want 0111", {fw_stage_o, fw_regs_o}); end
        @(negedge clk_i); id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk_i); id_set(5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        checks++; if ({fw_stage_o, fw_regs_o} !== 4'b0000) begin errors++; $display("FAIL x0_sel: got %b want 0000", {fw_stage_o, fw_regs_o}); end
        // x13 writer is in EX, but this consumer does not read its sources.
        @(negedge clk_i); id_set(5'd13, 5'd13, 1'b0, 1'b0, 5'd14, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        checks++; if ({fw_stage_o, fw_regs_o} !== 4'b0000) begin errors++; $display("FAIL unused_sel: got %b want 0000", {fw_stage_o, fw_regs_o}); end
    endtask

    // DIV x14 (reading x17 from EX) occupies EX for 3 busy cycles.
    task automatic test_multicycle();
        drain();
        @(negedge clk_i); id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd17, 1'b0, 1'b0);
        @(negedge clk_i); id_set(5'd17, 5'd0, 1'b1, 1'b0, 5'd14, 1'b0, 1'b1);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mc_entry_stall: got %0b want 0", stall_o); end
        @(posedge clk_i); #1;
        checks++; if (mc_busy_o !== 1'b1) begin errors++; $display("FAIL mc_busy: got %0b want 1", mc_busy_o); end
        @(negedge clk_i); id_set(5'd14, 5'd0, 1'b1, 1'b0, 5'd15, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) mc_done_i = 1'b1;
            #1;
            checks++; if ({stall_o, mc_busy_o} !== 2'b11) begin errors++; $display("FAIL mc_cycle%0d: stall/busy got %b want 11", i, {stall_o, mc_busy_o}); end
            checks++; if ({fw_stage_o, fw_regs_o} !== 4'b0101) begin errors++; $display("FAIL mc_hold%0d: got %b want 0101", i, {fw_stage_o, fw_regs_o}); end
            @(negedge clk_i);
        end
        mc_done_i = 1'b0;
        #1;
        checks++; if (mc_busy_o !== 1'b0) begin errors++; $display("FAIL mc_done_busy: got %0b want 0", mc_busy_o); end
        checks++; if ({fw_stage_o, fw_regs_o} !== 4'b0000) begin errors++; $display("FAIL mc_done_fw: got %b want 0000", {fw_stage_o, fw_regs_o}); end
        checks++; if (stall_cnt_o !== 4'd5) begin errors++; $display("FAIL mc_cnt: got %0d want 5", stall_cnt_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mc_after_stall: got %0b want 0", stall_o); end
        @(posedge clk_i); #1;
        checks++; if ({fw_stage_o, fw_regs_o} !== 4'b1001) begin errors++; $display("FAIL mc_result_fw: got %b want 1001", {fw_stage_o, fw_regs_o}); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mc_no_err: got %0b want 0", err_o); end
    endtask

    // No done for 6 cycles: err after the 4th busy edge, sticky, FSM waits.
    task automatic test_timeout();
        drain();
        @(negedge clk_i); id_set(5'd0, 5'd0, 1'b0, 1'b0, 5'd20, 1'b0, 1'b1);
        @(negedge clk_i); id_none(); flush_i = 1'b1; #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL to_flush_stall: got %0b want 1", stall_o); end
        @(negedge clk_i); flush_i = 1'b0;
        @(posedge clk_i); @(posedge clk_i); #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL to_early: got %0b want 0 after 3 cycles", err_o); end
        @(posedge clk_i); #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL to_rise: got %0b want 1 after 4 cycles", err_o); end
        repeat (2) @(posedge clk_i); #1;
        checks++; if ({err_o, mc_busy_o} !== 2'b11) begin errors++; $display("FAIL to_wait: err/busy got %b want 11", {err_o, mc_busy_o}); end
        @(negedge clk_i); mc_done_i = 1'b1;
        @(posedge clk_i); #1; mc_done_i = 1'b0;
        checks++; if ({err_o, mc_busy_o} !== 2'b10) begin errors++; $display("FAIL to_sticky: err/busy got %b want 10", {err_o, mc_busy_o}); end
        checks++; if (stall_cnt_o !== 4'd12) begin errors++; $display("FAIL to_cnt: got %0d want 12", stall_cnt_o); end
    endtask

    // Counter saturates at 15, then reset mid-op clears everything at once.
    task automatic test_sat_reset();
        @(negedge clk_i); id_set(5'd20, 5'd0, 1'b1, 1'b0, 5'd21, 1'b0, 1'b1);
        @(posedge clk_i); #1;
        checks++; if ({fw_stage_o, fw_regs_o} !== 4'b1001) begin errors++; $display("FAIL sat_entry_fw: got %b want 1001", {fw_stage_o, fw_regs_o}); end
        @(negedge clk_i); id_none();
        repeat (4) @(posedge clk_i); #1;
        checks++; if (stall_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d want 15", stall_cnt_o); end
        @(negedge clk_i); rst_ni = 1'b0; #1;
        checks++; if ({stall_o, mc_busy_o, err_o} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b want 000", {stall_o, mc_busy_o, err_o}); end
        checks++; if ({fw_stage_o, fw_regs_o} !== 4'b0000) begin errors++; $display("FAIL rst_mid_fw: got %b want 0000", {fw_stage_o, fw_regs_o}); end
        checks++; if (stall_cnt_o !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", stall_cnt_o); end
        @(negedge clk_i); rst_ni = 1'b1;
        repeat (2) @(posedge clk_i); #1;
        checks++; if ({stall_o, mc_busy_o} !== 2'b00) begin errors++; $display("FAIL rst_abandon: got %b want 00", {stall_o, mc_busy_o}); end
    endtask

    initial begin
        test_reset();
        test_fwd_mem();
        test_load_use();
        test_flush();
        test_conflict();
        test_both_x0();
        test_multicycle();
        test_timeout();
        test_sat_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
